// File: rtl/cpu4004_pkg.sv
// ---------------------------------------------------------------------------
// cpu4004_pkg
// Shared constants for the 4-bit CPU program-flow logic:
//   - OP_*       : OPR nibble values of the flow-control / two-word opcodes
//   - CYC_*      : instruction phase numbers carried on the 3-bit cycle bus
//   - fsm_state_e: fetch FSM of pc_stack_ctrl (first word / second word)
//   - STACK_DEPTH, ADDR_W : default sizes of the return stack and PC
// ---------------------------------------------------------------------------
package cpu4004_pkg;

  localparam int STACK_DEPTH = 3;
  localparam int ADDR_W      = 12;

  localparam logic [3:0] OP_JCN = 4'h1;
  localparam logic [3:0] OP_FIM = 4'h2;
  localparam logic [3:0] OP_JIN = 4'h3;  // JIN when opa[0]=1, FIN otherwise
  localparam logic [3:0] OP_JUN = 4'h4;
  localparam logic [3:0] OP_JMS = 4'h5;
  localparam logic [3:0] OP_ISZ = 4'h7;
  localparam logic [3:0] OP_BBL = 4'hC;

  localparam logic [2:0] CYC_A1 = 3'd0;
  localparam logic [2:0] CYC_A2 = 3'd1;
  localparam logic [2:0] CYC_A3 = 3'd2;
  localparam logic [2:0] CYC_M1 = 3'd3;
  localparam logic [2:0] CYC_M2 = 3'd4;
  localparam logic [2:0] CYC_X1 = 3'd5;
  localparam logic [2:0] CYC_X2 = 3'd6;
  localparam logic [2:0] CYC_X3 = 3'd7;

  typedef enum logic {
    ST_FETCH1 = 1'b0,
    ST_FETCH2 = 1'b1
  } fsm_state_e;

  // Opcodes whose instruction occupies two ROM words.
  function automatic logic is_two_word(input logic [3:0] op);
    return (op == OP_JCN) || (op == OP_FIM) || (op == OP_JUN) ||
           (op == OP_JMS) || (op == OP_ISZ);
  endfunction

endpackage

// File: rtl/addr_stack.sv
// ---------------------------------------------------------------------------
// addr_stack
// Circular return-address stack with a single write pointer.
//   push  : store din at the write pointer and advance it. When already full
//           the oldest entry is overwritten, depth stays at DEPTH, ovf sets.
//   pop   : dout (entry just below the write pointer) is the popped value;
//           the pointer steps back. When empty the pointer still moves,
//           depth stays 0 and unf sets.
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears entries)
//   push, pop         one-clk strobes, never asserted together
//   din  [W]          value to push
//   dout [W]          top-of-stack, combinational (valid in the pop clk)
//   depth[CNT_W]      number of valid entries 0..DEPTH
//   ovf, unf          sticky overflow / underflow flags
// ---------------------------------------------------------------------------
module addr_stack #(
  parameter int DEPTH = 3,
  parameter int W     = 12,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] depth,
  output logic             ovf,
  output logic             unf
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] wp_inc, wp_dec;
  logic [CNT_W-1:0] depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             full, empty;

  // Pointer arithmetic wraps modulo DEPTH, which need not be a power of two.
  assign wp_inc = (wp_q == LAST_PTR) ? '0 : wp_q + PTR_W'(1);
  assign wp_dec = (wp_q == '0) ? LAST_PTR : wp_q - PTR_W'(1);
  assign full   = (depth_q == FULL_CNT);
  assign empty  = (depth_q == '0);

  always_comb begin
    wp_d    = wp_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (push) begin
      wp_d = wp_inc;
      if (full) ovf_d = 1'b1;
      else      depth_d = depth_q + CNT_W'(1);
    end else if (pop) begin
      wp_d = wp_dec;
      if (empty) unf_d = 1'b1;
      else       depth_d = depth_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wp_q    <= wp_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wp_q == PTR_W'(i))) mem_q[i] <= din;
      end
    end
  end

  assign dout  = mem_q[wp_dec];
  assign depth = depth_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: rtl/pc_stack_ctrl.sv
// ---------------------------------------------------------------------------
// pc_stack_ctrl
// Program-flow controller of the 4-bit CPU. Latches OPR/OPA from the ROM
// nibble stream, tracks two-word instructions, owns the return stack and
// drives the PC's pc_load/pc_new for JCN, JUN, JMS, ISZ, JIN and BBL.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cycle[3]          instruction phase A1..X3 (0..7)
//   rom_nibble[4]     ROM data, upper nibble at M1, lower at M2
//   pc_addr[ADDR_W]   address of the word fetched in this instruction cycle
//   acc_zero, carry_flag, test_in, isz_nonzero, reg_pair[8]
//                     condition / data inputs, sampled only at X3
//   opr, opa          latched opcode / modifier of the current instruction
//   second_word       high for the whole second-word instruction cycle
//   pc_load           one-clk pulse in the clk following X3 (decision made
//                     at the X3 edge, so it is aligned with pc_new)
//   pc_new[ADDR_W]    registered jump/return target, held until next load
//   stack_depth, stack_ovf, stack_unf   return-stack status
// ---------------------------------------------------------------------------
module pc_stack_ctrl
  import cpu4004_pkg::*;
#(
  parameter int STACK_DEPTH = cpu4004_pkg::STACK_DEPTH,
  parameter int ADDR_W      = cpu4004_pkg::ADDR_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [2:0]                         cycle,
  input  logic [3:0]                         rom_nibble,
  input  logic [ADDR_W-1:0]                  pc_addr,
  input  logic                               acc_zero,
  input  logic                               carry_flag,
  input  logic                               test_in,
  input  logic                               isz_nonzero,
  input  logic [7:0]                         reg_pair,
  output logic [3:0]                         opr,
  output logic [3:0]                         opa,
  output logic                               second_word,
  output logic                               pc_load,
  output logic [ADDR_W-1:0]                  pc_new,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
  output logic                               stack_ovf,
  output logic                               stack_unf
);

  fsm_state_e        state_q, state_d;
  logic [3:0]        opr_q, opr_d;
  logic [3:0]        opa_q, opa_d;
  logic [3:0]        hi_q, hi_d;
  logic [3:0]        lo_q, lo_d;
  logic              armed_q, armed_d;
  logic              pc_load_q, pc_load_d;
  logic [ADDR_W-1:0] pc_new_q, pc_new_d;

  logic              stk_push, stk_pop;
  logic [ADDR_W-1:0] stk_dout;

  logic [ADDR_W-1:0] pa1;
  logic [ADDR_W-1:0] page_target;
  logic [ADDR_W-1:0] far_target;
  logic              jcn_cond;

  // Targets are taken relative to the word after the one just fetched, so
  // a second word at xFF lands in the following page and FFF wraps to 000.
  assign pa1         = pc_addr + ADDR_W'(1);
  assign page_target = {pa1[ADDR_W-1:8], hi_q, lo_q};
  assign far_target  = ADDR_W'({opa_q, hi_q, lo_q});
  assign jcn_cond    = ((opa_q[2] & acc_zero) | (opa_q[1] & carry_flag) |
                        (opa_q[0] & ~test_in)) ^ opa_q[3];

  addr_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pa1),
    .dout  (stk_dout),
    .depth (stack_depth),
    .ovf   (stack_ovf),
    .unf   (stack_unf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH1;
      opr_q     <= '0;
      opa_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      armed_q   <= 1'b0;
      pc_load_q <= 1'b0;
      pc_new_q  <= '0;
    end else begin
      state_q   <= state_d;
      opr_q     <= opr_d;
      opa_q     <= opa_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      armed_q   <= armed_d;
      pc_load_q <= pc_load_d;
      pc_new_q  <= pc_new_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opr_d     = opr_q;
    opa_d     = opa_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    armed_d   = armed_q;
    pc_load_d = 1'b0;
    pc_new_d  = pc_new_q;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;

    case (cycle)
      CYC_M1: begin
        armed_d = 1'b1;
        if (state_q == ST_FETCH1) opr_d = rom_nibble;
        else                      hi_d  = rom_nibble;
      end
      CYC_M2: begin
        if (state_q == ST_FETCH1) opa_d = rom_nibble;
        else                      lo_d  = rom_nibble;
      end
      CYC_X3: begin
        armed_d = 1'b0;
        // Without a preceding M1 the latched words are not trustworthy
        // (e.g. reset released mid-cycle), so nothing is decided.
        if (armed_q) begin
          if (state_q == ST_FETCH1) begin
            if (is_two_word(opr_q)) begin
              state_d = ST_FETCH2;
            end else if ((opr_q == OP_JIN) && opa_q[0]) begin
              pc_load_d = 1'b1;
              pc_new_d  = {pa1[ADDR_W-1:8], reg_pair};
            end else if (opr_q == OP_BBL) begin
              stk_pop   = 1'b1;
              pc_load_d = 1'b1;
              pc_new_d  = stk_dout;
            end
          end else begin
            state_d = ST_FETCH1;
            case (opr_q)
              OP_JUN: begin
                pc_load_d = 1'b1;
                pc_new_d  = far_target;
              end
              OP_JMS: begin
                stk_push  = 1'b1;
                pc_load_d = 1'b1;
                pc_new_d  = far_target;
              end
              OP_JCN: begin
                if (jcn_cond) begin
                  pc_load_d = 1'b1;
                  pc_new_d  = page_target;
                end
              end
              OP_ISZ: begin
                if (isz_nonzero) begin
                  pc_load_d = 1'b1;
                  pc_new_d  = page_target;
                end
              end
              default: ;  // FIM: data fetch only, no flow change
            endcase
          end
        end
      end
      default: ;
    endcase
  end

  assign opr         = opr_q;
  assign opa         = opa_q;
  assign second_word = (state_q == ST_FETCH2);
  assign pc_load     = pc_load_q;
  assign pc_new      = pc_new_q;

endmodule

// File: tb/tb_pc_stack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_stack_ctrl
// Directed and random instruction streams against a behavioural model of
// the program-flow rules (first/second word tracking, jump targets and a
// 3-entry circular return stack kept as a plain array).
// ---------------------------------------------------------------------------
module tb_pc_stack_ctrl;

  logic        clk;
  logic        rst;
  logic [2:0]  cycle;
  logic [3:0]  rom_nibble;
  logic [11:0] pc_addr;
  logic        acc_zero, carry_flag, test_in, isz_nonzero;
  logic [7:0]  reg_pair;
  logic [3:0]  opr, opa;
  logic        second_word, pc_load;
  logic [11:0] pc_new;
  logic [1:0]  stack_depth;
  logic        stack_ovf, stack_unf;

  pc_stack_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cycle       (cycle),
    .rom_nibble  (rom_nibble),
    .pc_addr     (pc_addr),
    .acc_zero    (acc_zero),
    .carry_flag  (carry_flag),
    .test_in     (test_in),
    .isz_nonzero (isz_nonzero),
    .reg_pair    (reg_pair),
    .opr         (opr),
    .opa         (opa),
    .second_word (second_word),
    .pc_load     (pc_load),
    .pc_new      (pc_new),
    .stack_depth (stack_depth),
    .stack_ovf   (stack_ovf),
    .stack_unf   (stack_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Flag values presented at X3 (other phases get random noise).
  logic       x_az, x_cf, x_ti, x_iz;
  logic [7:0] x_rp;

  // Reference model state.
  logic        m_second;
  logic [3:0]  m_opr, m_opa;
  logic        exp_load;
  logic [11:0] exp_new;
  logic [11:0] ring [3];
  int          wp, dep;
  logic        m_ovf, m_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_second = 1'b0; m_opr = 4'h0; m_opa = 4'h0;
    exp_load = 1'b0; exp_new = 12'h000;
    for (int i = 0; i < 3; i++) ring[i] = 12'h000;
    wp = 0; dep = 0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic model_push(input logic [11:0] v);
    ring[wp] = v;
    wp = (wp + 1) % 3;
    if (dep == 3) m_ovf = 1'b1;
    else          dep = dep + 1;
  endtask

  task automatic model_pop(output logic [11:0] v);
    wp = (wp + 2) % 3;
    v  = ring[wp];
    if (dep == 0) m_unf = 1'b1;
    else          dep = dep - 1;
  endtask

  task automatic model_step(input logic [7:0] word, input logic [11:0] addr);
    logic [11:0] pa1, popped;
    logic [3:0]  hi, lo;
    logic        jump;
    pa1 = addr + 12'd1;
    exp_load = 1'b0;
    if (!m_second) begin
      m_opr = word[7:4];
      m_opa = word[3:0];
      case (m_opr)
        4'h1, 4'h2, 4'h4, 4'h5, 4'h7: m_second = 1'b1;
        4'h3: if (m_opa[0]) begin exp_load = 1'b1; exp_new = {pa1[11:8], x_rp}; end
        4'hC: begin model_pop(popped); exp_load = 1'b1; exp_new = popped; end
        default: ;
      endcase
    end else begin
      hi = word[7:4];
      lo = word[3:0];
      m_second = 1'b0;
      case (m_opr)
        4'h4: begin exp_load = 1'b1; exp_new = {m_opa, hi, lo}; end
        4'h5: begin model_push(pa1); exp_load = 1'b1; exp_new = {m_opa, hi, lo}; end
        4'h1: begin
          jump = ((m_opa[2] && x_az) || (m_opa[1] && x_cf) || (m_opa[0] && !x_ti)) != m_opa[3];
          if (jump) begin exp_load = 1'b1; exp_new = {pa1[11:8], hi, lo}; end
        end
        4'h7: if (x_iz) begin exp_load = 1'b1; exp_new = {pa1[11:8], hi, lo}; end
        default: ;
      endcase
    end
  endtask

  task automatic drive_phase(input int c, input logic [7:0] word, input logic [11:0] addr);
    cycle      = 3'(c);
    pc_addr    = addr;
    rom_nibble = (c == 3) ? word[7:4] : (c == 4) ? word[3:0] : 4'($urandom_range(0, 15));
    if (c == 7) begin
      acc_zero = x_az; carry_flag = x_cf; test_in = x_ti; isz_nonzero = x_iz; reg_pair = x_rp;
    end else begin
      acc_zero    = 1'($urandom_range(0, 1));
      carry_flag  = 1'($urandom_range(0, 1));
      test_in     = 1'($urandom_range(0, 1));
      isz_nonzero = 1'($urandom_range(0, 1));
      reg_pair    = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc_load"},     32'(pc_load),     32'(exp_load));
    chk({tag, ".pc_new"},      32'(pc_new),      32'(exp_new));
    chk({tag, ".second_word"}, 32'(second_word), 32'(m_second));
    chk({tag, ".opr"},         32'(opr),         32'(m_opr));
    chk({tag, ".opa"},         32'(opa),         32'(m_opa));
    chk({tag, ".depth"},       32'(stack_depth), 32'(dep));
    chk({tag, ".ovf"},         32'(stack_ovf),   32'(m_ovf));
    chk({tag, ".unf"},         32'(stack_unf),   32'(m_unf));
  endtask

  // One full A1..X3 instruction cycle, then an A1 clk where results are checked.
  task automatic do_cycle(input string tag, input logic [7:0] word, input logic [11:0] addr);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 4) chk({tag, ".second_word_mid"}, 32'(second_word), 32'(m_second));
      drive_phase(c, word, addr);
    end
    model_step(word, addr);
    @(negedge clk);
    drive_phase(0, 8'h00, addr);
    check_all(tag);
    $display("[TB] %s word=%02h addr=%03h pc_load=%0d pc_new=%03h depth=%0d", tag, word, addr, pc_load, pc_new, stack_depth);
  endtask

  task automatic set_x3(input logic az, input logic cf, input logic ti, input logic iz, input logic [7:0] rp);
    x_az = az; x_cf = cf; x_ti = ti; x_iz = iz; x_rp = rp;
  endtask

  initial begin
    logic [3:0] op;
    logic [7:0] word;

    rst = 1'b1;
    set_x3(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    drive_phase(0, 8'h00, 12'h000);
    model_reset();

    // Reset held through A1..M2 (BBL presented at M1), released at X1.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 3) check_all("reset");
      if (c == 5) rst = 1'b0;
      drive_phase(c, 8'hC0, 12'h123);
    end
    @(negedge clk);
    drive_phase(0, 8'h00, 12'h000);
    check_all("release_x1");

    // JUN 0x45,0x67
    do_cycle("jun_w1", 8'h45, 12'h010);
    do_cycle("jun_w2", 8'h67, 12'h011);
    chk("jun_target", 32'(pc_new), 32'h567);
    @(negedge clk);
    chk("jun_pulse_width", 32'(pc_load), 32'h0);

    // JMS 0x52,0x34 then BBL
    do_cycle("jms_w1", 8'h52, 12'h0FE);
    do_cycle("jms_w2", 8'h34, 12'h0FF);
    chk("jms_target", 32'(pc_new), 32'h234);
    do_cycle("bbl", 8'hC0, 12'h234);
    chk("bbl_return", 32'(pc_new), 32'h100);

    // JCN on acc_zero, taken and not taken; JCN on TEST
    set_x3(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    do_cycle("jcn_az1_w1", 8'h14, 12'h2FE);
    do_cycle("jcn_az1_w2", 8'h80, 12'h2FF);
    chk("jcn_page_cross", 32'(pc_new), 32'h380);
    set_x3(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
    do_cycle("jcn_az0_w1", 8'h14, 12'h2FE);
    do_cycle("jcn_az0_w2", 8'h80, 12'h2FF);
    set_x3(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    do_cycle("jcn_t1_w1", 8'h11, 12'h400);
    do_cycle("jcn_t1_w2", 8'h22, 12'h401);
    set_x3(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    do_cycle("jcn_t0_w1", 8'h11, 12'h400);
    do_cycle("jcn_t0_w2", 8'h22, 12'h401);
    chk("jcn_test_target", 32'(pc_new), 32'h422);

    // ISZ taken / not taken, FIM, JIN across a page
    set_x3(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    do_cycle("isz_nz_w1", 8'h73, 12'h100);
    do_cycle("isz_nz_w2", 8'h20, 12'h101);
    chk("isz_target", 32'(pc_new), 32'h120);
    set_x3(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    do_cycle("isz_z_w1", 8'h73, 12'h100);
    do_cycle("isz_z_w2", 8'h20, 12'h101);
    do_cycle("fim_w1", 8'h20, 12'h200);
    do_cycle("fim_w2", 8'h55, 12'h201);
    set_x3(1'b0, 1'b0, 1'b0, 1'b0, 8'hAB);
    do_cycle("jin", 8'h33, 12'h4FF);
    chk("jin_target", 32'(pc_new), 32'h5AB);
    do_cycle("fin", 8'h32, 12'h4FF);

    // Four JMS: overflow; three BBL; fourth BBL underflows
    for (int k = 0; k < 4; k++) begin
      do_cycle("jms4_w1", 8'h5A, 12'(12'h9FF + 2 * k));
      do_cycle("jms4_w2", 8'h00, 12'(12'hA00 + 2 * k));
    end
    chk("ovf_after_4", 32'(stack_ovf), 32'h1);
    chk("depth_after_4", 32'(stack_depth), 32'h3);
    do_cycle("bbl_a", 8'hC0, 12'hA00);
    chk("ret_a07", 32'(pc_new), 32'hA07);
    do_cycle("bbl_b", 8'hC0, 12'hA00);
    chk("ret_a05", 32'(pc_new), 32'hA05);
    do_cycle("bbl_c", 8'hC0, 12'hA00);
    chk("ret_a03", 32'(pc_new), 32'hA03);
    do_cycle("bbl_d", 8'hC0, 12'hA00);
    chk("unf_after_4", 32'(stack_unf), 32'h1);
    chk("depth_after_unf", 32'(stack_depth), 32'h0);

    // Reset pulsed at M2 of a JUN second word, released at X1
    do_cycle("rst_jun_w1", 8'h45, 12'h600);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 5) begin
        chk("rst_mid.second_word", 32'(second_word), 32'h0);
        chk("rst_mid.pc_load", 32'(pc_load), 32'h0);
        rst = 1'b0;
      end
      if (c == 4) rst = 1'b1;
      drive_phase(c, 8'h67, 12'h601);
    end
    model_reset();
    @(negedge clk);
    drive_phase(0, 8'h00, 12'h000);
    check_all("rst_mid_after");

    // Random instruction stream
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 7))
        0: op = 4'h1;
        1: op = 4'h2;
        2: op = 4'h3;
        3: op = 4'h4;
        4: op = 4'h5;
        5: op = 4'h7;
        6: op = 4'hC;
        default: op = 4'($urandom_range(0, 15));
      endcase
      set_x3(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      word = m_second ? 8'($urandom_range(0, 255)) : {op, 4'($urandom_range(0, 15))};
      do_cycle("rand", word, 12'($urandom_range(0, 4095)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_stack_ctrl.md
Name: pc_stack_ctrl

Overview:
Program-flow controller for the 4-bit CPU core. Captures OPR/OPA from the ROM nibble stream and tracks one-word versus two-word instructions. Drives the PC module's pc_load/pc_new for JCN, JUN, JMS, ISZ, JIN and BBL. Owns the 3-level return-address stack. Sits between rom/pc and decoder_with_cc, replacing the tied-off pc_load/pc_new in cpu_top.

Parameters:
STACK_DEPTH, 3, number of return-address entries (4004 = 3)
ADDR_W, 12, PC/ROM address width

Ports:
clk  in  1  system clock; cycle advances one step per clk
rst  in  1  synchronous reset, active-high
cycle  in  3  instruction phase 0..7 (A1,A2,A3,M1,M2,X1,X2,X3)
rom_nibble  in  4  ROM output; valid at M1 (upper) and M2 (lower)
pc_addr  in  12  address of the word fetched in the current instruction cycle
acc_zero  in  1  accumulator == 0
carry_flag  in  1  carry/link flag
test_in  in  1  TEST pin level
isz_nonzero  in  1  ISZ register result != 0, valid by X3 of the second word
reg_pair  in  8  register-pair value for JIN
opr  out  4  latched opcode of the current instruction
opa  out  4  latched modifier of the current instruction
second_word  out  1  high for the whole second-word cycle; decoder suppresses execute
pc_load  out  1  one-clk pulse at X3; PC takes pc_new instead of incrementing
pc_new  out  12  jump/return target, registered, held until next load
stack_depth  out  2  valid entries, 0..3
stack_ovf  out  1  sticky push-when-full
stack_unf  out  1  sticky pop-when-empty

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: opr=opa=0, pc_new=0, pc_load=0, second_word=0, stack_depth=0, ovf=unf=0, all stack entries 0, FSM=FETCH1, armed=0. Reset mid-instruction abandons the instruction with no load and no push.
- armed bit: set at M1, cleared at X3. An X3 decision requires armed=1, so release from reset mid-cycle produces no action until a full M1..X3 pass.
- FETCH1: M1 latches opr; M2 latches opa. At X3:
  - JCN(0001), FIM(0010), JUN(0100), JMS(0101), ISZ(0111): go to FETCH2.
  - JIN(0011, opa[0]=1): pc_load, pc_new={pa1[11:8], reg_pair}, where pa1=pc_addr+1 (mod 4096).
  - BBL(1100): pop, pc_load, pc_new=popped entry.
  - All other opcodes: no action.
- FETCH2: second_word=1. M1 latches hi nibble; M2 latches lo nibble; opr/opa unchanged. At X3, return to FETCH1 and:
  - JUN: pc_new={opa,hi,lo}, load.
  - JMS: push pa1, pc_new={opa,hi,lo}, load.
  - JCN: cond=(opa[2]&acc_zero)|(opa[1]&carry_flag)|(opa[0]&~test_in); jump=cond^opa[3]. If jump, pc_new={pa1[11:8],hi,lo}, load.
  - ISZ: if isz_nonzero, same in-page target, load.
  - FIM: no load.
- In-page jumps use the page of pc_addr+1, so a second word at xFF jumps into the next page (4004-compatible). Page wrap FFF→000.
- Stack: circular 3-entry with write pointer.
  - Push when depth=3 overwrites the oldest entry; depth stays 3; ovf set.
  - Pop when depth=0 returns entry[ptr-1] and moves the pointer; depth stays 0; unf set.
  - Push and pop never occur in the same clk.
- Flag sampling: acc_zero, carry_flag, test_in, isz_nonzero and reg_pair are sampled only at X3.

Decomposition:
- cpu4004_pkg: opcode constants (OP_JCN, OP_FIM, OP_JIN, OP_JUN, OP_JMS, OP_ISZ, OP_BBL), cycle constants CYC_A1..CYC_X3, FSM state enum, STACK_DEPTH.
- Sub-module addr_stack: circular 12-bit stack with push, pop, dout, depth, ovf and unf. Separately verifiable.

Test Plan:
- JUN 0x45, 0x67 at 0x010/0x011 -> FETCH2 second_word=1; at X3 pc_load=1 for one clk, pc_new=0x567; next cycle second_word=0.
- JMS 0x52, 0x34 at 0x0FE/0x0FF -> pc_new=0x234, depth=1; then BBL -> pc_new=0x100, depth=0.
- JCN 0x14, 0x80 at 0x2FE/0x2FF, acc_zero=1 -> pc_new=0x380; repeat with acc_zero=0 -> no pc_load. JCN 0x11 with test_in=1 -> no jump; test_in=0 -> jump.
- ISZ 0x73, 0x20 at 0x100/0x101: isz_nonzero=1 -> pc_new=0x120; isz_nonzero=0 -> no load. FIM -> two-word, never loads.
- Four JMS returning 0xA01, 0xA03, 0xA05, 0xA07 -> ovf=1, depth=3. Three BBL return 0xA07, 0xA05, 0xA03. Fourth BBL -> unf=1, depth=0.
- rst held at M2 of FETCH2 -> next clk second_word=0, no pc_load. Release at cycle 5 -> first X3 ignored (armed=0).
